// File: rtl/i2s_rx.sv
// I2S receiver: deserialises one left+right frame after each lrclk high-to-low edge.
// Optional macro I2S_RX_FRAME_CHECK_EN adds a frame_err pulse on aborted frames.
module i2s_rx #(
  parameter int BITSIZE = 24
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
`ifdef I2S_RX_FRAME_CHECK_EN
  output logic               frame_err,
`endif
  output logic [1:0]         dbg_state
);
  localparam int FRAME = 2 * BITSIZE;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FRAME-1:0]   shift_q, shift_d;
  logic [FRAME-1:0]   word;
  logic [BITSIZE-1:0] left_q, left_d, right_q, right_d;
  logic               valid_q, valid_d;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic               err_q, err_d;
`endif

  // Register contents with the current bit appended; the first frame bit ends up at the MSB.
  assign word = {shift_q[FRAME-2:0], sdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (lrclk) state_d = ARMED;
      end
      ARMED: begin
        if (!lrclk) begin
          state_d = SHIFT;
          shift_d = word;
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (lrclk) begin
          state_d = ARMED;
`ifdef I2S_RX_FRAME_CHECK_EN
          err_d   = 1'b1;
`endif
        end else begin
          shift_d = word;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME - 1)) begin
            left_d  = word[FRAME-1:BITSIZE];
            right_d = word[BITSIZE-1:0];
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
`ifdef I2S_RX_FRAME_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;
  assign dbg_state  = state_q;
`ifdef I2S_RX_FRAME_CHECK_EN
  assign frame_err  = err_q;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: 24-bit frame table plus abort, reset and 32-bit sequences.
module tb_i2s_rx;
  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [23:0] left24, right24;
  logic [31:0] left32, right32;
  logic        valid24, valid32;
  logic [1:0]  st24, st32;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic        ferr24, ferr32;
`endif

  i2s_rx #(.BITSIZE(24)) dut24 (
    .sclk(sclk), .rst(rst), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left24), .right_chan(right24), .valid(valid24),
`ifdef I2S_RX_FRAME_CHECK_EN
    .frame_err(ferr24),
`endif
    .dbg_state(st24)
  );

  i2s_rx #(.BITSIZE(32)) dut32 (
    .sclk(sclk), .rst(rst), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left32), .right_chan(right32), .valid(valid32),
`ifdef I2S_RX_FRAME_CHECK_EN
    .frame_err(ferr32),
`endif
    .dbg_state(st32)
  );

  // Clock / reset
  always #5 sclk = ~sclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  logic [47:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          valid_cnt24 = 0, valid_cnt32 = 0, ferr_cnt = 0;
  int          last_valid_cyc = -1, last_valid32_cyc = -1, last_bit_cyc = 0;
  logic [23:0] mdl_left = '0, mdl_right = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: change inputs away from the active edge, then observe just after it.
  task automatic tick(input logic r, input logic lr, input logic sd);
    logic [47:0] e;
    @(negedge sclk);
    rst   = r;
    lrclk = lr;
    sdata = sd;
    @(posedge sclk);
    #1;
    cyc++;
    if (valid24 === 1'b1) begin
      valid_cnt24++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid24", 64'(valid24), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("left24", 64'(left24), 64'(e[47:24]));
        check("right24", 64'(right24), 64'(e[23:0]));
        mdl_left  = e[47:24];
        mdl_right = e[23:0];
      end
    end
    if (valid32 === 1'b1) begin
      valid_cnt32++;
      last_valid32_cyc = cyc;
    end
`ifdef I2S_RX_FRAME_CHECK_EN
    if (ferr24 === 1'b1) ferr_cnt++;
`endif
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b0, w[i]);
    last_bit_cyc = cyc;
  endtask

  task automatic send_frame24(input logic [23:0] l, input logic [23:0] r, input int hi,
                              input int pad, input bit toggle);
    for (int i = 0; i < hi; i++)
      tick(1'b0, 1'b1, toggle ? 1'((i + 1) & 1) : 1'($urandom_range(0, 1)));
    exp_q.push_back({l, r});
    send_bits({16'h0, l, r}, 48);
    for (int i = 0; i < pad; i++) tick(1'b0, 1'b0, toggle ? 1'(i & 1) : 1'b0);
  endtask

  typedef struct {
    logic [23:0] left;
    logic [23:0] right;
    int          hi;
    int          pad;
    bit          toggle;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int vc, fc, v32;
    vecs[0] = '{left: 24'hA5F00F, right: 24'h123456, hi: 1,  pad: 16, toggle: 1'b0};
    vecs[1] = '{left: 24'h000001, right: 24'h00FF00, hi: 1,  pad: 0,  toggle: 1'b0};
    vecs[2] = '{left: 24'h800000, right: 24'h7FFFFF, hi: 1,  pad: 0,  toggle: 1'b0};
    vecs[3] = '{left: 24'h3C3C3C, right: 24'hAAAAAA, hi: 10, pad: 16, toggle: 1'b1};
    vecs[4] = '{left: 24'h000000, right: 24'hFFFFFF, hi: 3,  pad: 5,  toggle: 1'b0};

    // Reset state
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("rst_left24", 64'(left24), 64'd0);
    check("rst_right24", 64'(right24), 64'd0);
    check("rst_valid24", 64'(valid24), 64'd0);
    check("rst_state24", 64'(st24), 64'd0);
    check("rst_left32", 64'(left32), 64'd0);
    check("rst_valid32", 64'(valid32), 64'd0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("rst_ferr", 64'(ferr24), 64'd0);
`endif
    tick(1'b0, 1'b0, 1'b1);

    // Frame table: one valid per frame, visible right after the 48th bit edge
    foreach (vecs[k]) begin
      vc = valid_cnt24;
      fc = ferr_cnt;
      send_frame24(vecs[k].left, vecs[k].right, vecs[k].hi, vecs[k].pad, vecs[k].toggle);
      check($sformatf("vec%0d_valid_count", k), 64'(valid_cnt24 - vc), 64'd1);
      check($sformatf("vec%0d_valid_timing", k), 64'(last_valid_cyc), 64'(last_bit_cyc));
      check($sformatf("vec%0d_ferr_count", k), 64'(ferr_cnt - fc), 64'd0);
    end

    // Outputs hold while lrclk stays low after the frame
    vc = valid_cnt24;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("hold_left", 64'(left24), 64'(mdl_left));
    check("hold_right", 64'(right24), 64'(mdl_right));
    check("hold_no_valid", 64'(valid_cnt24 - vc), 64'd0);

    // Abort after 30 bits, then a complete frame
    vc = valid_cnt24;
    fc = ferr_cnt;
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b1, 1'b0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("abort_ferr_pulse", 64'(ferr24), 64'd1);
`endif
    check("abort_no_valid", 64'(valid24), 64'd0);
    check("abort_left_kept", 64'(left24), 64'(mdl_left));
    check("abort_state_armed", 64'(st24), 64'd1);
    send_frame24(24'hFFFFFF, 24'h000000, 0, 16, 1'b0);
    check("abort_valid_count", 64'(valid_cnt24 - vc), 64'd1);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("abort_ferr_count", 64'(ferr_cnt - fc), 64'd1);
`endif

    // Reset at bit 20, released two cycles later with lrclk low
    vc = valid_cnt24;
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    mdl_left  = '0;
    mdl_right = '0;
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("midrst_left", 64'(left24), 64'd0);
    check("midrst_right", 64'(right24), 64'd0);
    check("midrst_no_valid", 64'(valid_cnt24 - vc), 64'd0);
    check("midrst_state_idle", 64'(st24), 64'd0);
    send_frame24(24'h5A5A5A, 24'hC3C3C3, 1, 0, 1'b0);
    check("postrst_valid_count", 64'(valid_cnt24 - vc), 64'd1);

    // 32-bit instance: full 64-bit frame; 24-bit instance takes the first 48 bits
    v32 = valid_cnt32;
    vc  = valid_cnt24;
    tick(1'b0, 1'b1, 1'b0);
    exp_q.push_back(48'hDEADBEEFCAFE);
    send_bits(64'hDEADBEEFCAFEF00D, 64);
    check("b32_valid_count", 64'(valid_cnt32 - v32), 64'd1);
    check("b32_valid_timing", 64'(last_valid32_cyc), 64'(last_bit_cyc));
    check("b32_left", 64'(left32), 64'hDEADBEEF);
    check("b32_right", 64'(right32), 64'hCAFEF00D);
    check("b32_state_hold", 64'(st32), 64'd3);
    check("b32_24bit_valid_count", 64'(valid_cnt24 - vc), 64'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("b32_valid_drop", 64'(valid32), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
